// File: rtl/iter_divider.sv
// Iterative restoring radix-2 divider: 32 BUSY steps per request, result registered on
// the BUSY->DONE edge with independent sign correction for quotient and remainder.
module iter_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_begin,
    input  logic        div_sign,
    input  logic        div_dividend_sign,
    input  logic [31:0] div_dividend,
    input  logic [31:0] div_divisor,
    output logic [31:0] div_quotient,
    output logic [31:0] div_remainder,
    output logic        div_done
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] dvd_q, dvd_d;     // dividend bits shift out the top, quotient bits in the bottom
    logic [31:0] dvs_q, dvs_d;
    logic        sign_q, sign_d;
    logic        rsign_q, rsign_d;
    logic [32:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] remo_q, remo_d;

    // One restoring step; a borrow out of bit 33 means the trial subtraction went negative.
    logic [33:0] shifted;
    logic [33:0] diff;
    logic        qbit;
    logic [32:0] rem_next;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;

    always_comb begin
        shifted  = {rem_q, dvd_q[31]};
        diff     = shifted - {2'b00, dvs_q};
        qbit     = ~diff[33];
        rem_next = qbit ? diff[32:0] : shifted[32:0];
        quo_mag  = {dvd_q[30:0], qbit};
        rem_mag  = rem_next[31:0];
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sign_d  = sign_q;
        rsign_d = rsign_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        unique case (state_q)
            StIdle: begin
                if (div_begin) begin
                    dvd_d   = div_dividend;
                    dvs_d   = div_divisor;
                    sign_d  = div_sign;
                    rsign_d = div_dividend_sign;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!div_begin) begin
                    // Flushed from EX: drop the operation, results stay untouched.
                    state_d = StIdle;
                end else begin
                    rem_d = rem_next;
                    dvd_d = quo_mag;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StDone;
                        quo_d   = sign_q ? (~quo_mag + 32'd1) : quo_mag;
                        remo_d  = rsign_q ? (~rem_mag + 32'd1) : rem_mag;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sign_q  <= 1'b0;
            rsign_q <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sign_q  <= sign_d;
            rsign_q <= rsign_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
        end
    end

    assign div_quotient  = quo_q;
    assign div_remainder = remo_q;
    assign div_done      = (state_q == StDone);

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: stimulus pushes expected results, a negedge monitor
// pops and compares on every div_done.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_begin;
    logic        div_sign;
    logic        div_dividend_sign;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;

    iter_divider dut (
        .clk               (clk),
        .rst               (rst),
        .div_begin         (div_begin),
        .div_sign          (div_sign),
        .div_dividend_sign (div_dividend_sign),
        .div_dividend      (div_dividend),
        .div_divisor       (div_divisor),
        .div_quotient      (div_quotient),
        .div_remainder     (div_remainder),
        .div_done          (div_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   done_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Done is expected in the 33rd cycle after acceptance, i.e. after the 32nd edge
    // following the accepting edge.
    always @(negedge clk) begin
        if (rst && div_done) begin
            done_count++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", div_quotient, mon_e.q);
                check("remainder", div_remainder, mon_e.r);
                check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Called #1 after a posedge P; acceptance happens at edge P+1, done after edge P+33.
    task automatic start_op(input logic [31:0] dvd, input logic [31:0] dvs, input logic s,
                            input logic ds, input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        div_dividend      = dvd;
        div_divisor       = dvs;
        div_sign          = s;
        div_dividend_sign = ds;
        div_begin         = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.cyc = cyc + 33;
        sb.push_back(e);
    endtask

    task automatic do_div(input logic [31:0] dvd, input logic [31:0] dvs, input logic s,
                          input logic ds, input logic [31:0] eq, input logic [31:0] er);
        @(posedge clk);
        #1;
        start_op(dvd, dvs, s, ds, eq, er);
        @(posedge clk);
        #1;
        // Operands must be ignored after the accepting edge.
        div_dividend      = 32'hDEADBEEF;
        div_divisor       = 32'h00000003;
        div_sign          = ~s;
        div_dividend_sign = ~ds;
        repeat (32) @(posedge clk);
        #1;
        div_begin = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

    int saved_done;

    initial begin
        rst               = 1'b0;
        div_begin         = 1'b0;
        div_sign          = 1'b0;
        div_dividend_sign = 1'b0;
        div_dividend      = '0;
        div_divisor       = '0;
        #3;
        check("rst_quotient", div_quotient, 32'h0);
        check("rst_remainder", div_remainder, 32'h0);
        check("rst_done", {31'b0, div_done}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2);
        do_div(32'h12345678, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678);
        do_div(32'h80000000, 32'd1, 1'b1, 1'b0, 32'h80000000, 32'h0);
        do_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd1, 32'd0);
        do_div(32'd5, 32'd10, 1'b0, 1'b0, 32'd0, 32'd5);
        do_div(32'd0, 32'd3, 1'b0, 1'b1, 32'd0, 32'd0);
        do_div(32'd7, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);

        // Flush at BUSY cycle 10: no done, results keep the -7/2 values.
        saved_done = done_count;
        @(posedge clk);
        #1;
        div_dividend      = 32'd50;
        div_divisor       = 32'd5;
        div_sign          = 1'b0;
        div_dividend_sign = 1'b0;
        div_begin         = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 div_begin = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_count), 32'(saved_done));
        check("abort_quotient", div_quotient, 32'hFFFFFFFD);
        check("abort_remainder", div_remainder, 32'hFFFFFFFF);
        do_div(32'd77, 32'd8, 1'b0, 1'b0, 32'd9, 32'd5);

        // Reset at BUSY cycle 20, then a held div_begin restarts after release.
        @(posedge clk);
        #1;
        start_op(32'd1000, 32'd3, 1'b0, 1'b0, 32'd333, 32'd1);
        void'(sb.pop_back());
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_quotient", div_quotient, 32'h0);
        check("midrst_remainder", div_remainder, 32'h0);
        check("midrst_done", {31'b0, div_done}, 32'h0);
        check("midrst_state", {30'b0, dut.state_q}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start_op(32'd1000, 32'd3, 1'b0, 1'b0, 32'd333, 32'd1);
        repeat (33) @(posedge clk);
        #1 div_begin = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'h0);
        check("total_dones", 32'(done_count), 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
